uart_apb_regfile: RTL and testbench
===================================

// Module: uart_apb_regfile
// PURPOSE
//  UART register bank that sits directly after the APB access FSM.
//  Consumes the FSM's single-cycle rd_en/wr_en strobes together with paddr/pwdata, and drives prdata.
//  Holds the control, baud and interrupt registers, and bridges register accesses to TX-FIFO push and RX-FIFO pop.
//  Gathers the sticky interrupt sources into a single level irq.
// PARAMETERS
//  ADDR_WIDTH  5      byte address width; registers are word-aligned, paddr[1:0] is ignored
//  DATA_WIDTH  32     APB data width; registers sit in the LSBs, unused bits read as 0
//  DIV_WIDTH   16     baud divisor width
//  BAUD_RST    16'd54 reset value of BAUD
// PORTS
//  pclk        in   1           APB clock; all state changes on its rising edge
//  preset_n    in   1           asynchronous active-low reset
//  paddr       in   ADDR_WIDTH  register byte address
//  pwdata      in   DATA_WIDTH  write data
//  rd_en       in   1           read strobe from the APB FSM (ACCESS & penable & ~pwrite)
//  wr_en       in   1           write strobe from the APB FSM (ACCESS & penable & pwrite)
//  prdata      out  DATA_WIDTH  read data
//  pslverr     out  1           slave error (see CONFIGURATION)
//  tx_wdata    out  8           byte pushed into the TX FIFO
//  tx_push     out  1           TX FIFO push pulse
//  tx_full     in   1           TX FIFO full
//  tx_empty    in   1           TX FIFO empty
//  tx_busy     in   1           transmitter shifting
//  rx_rdata    in   8           RX FIFO head, show-ahead
//  rx_pop      out  1           RX FIFO pop pulse
//  rx_empty    in   1           RX FIFO empty
//  rx_full     in   1           RX FIFO full
//  rx_push     in   1           receiver wrote a byte (event)
//  rx_ovr      in   1           receiver overrun (event)
//  ctrl_o      out  5           {stop2, par_odd, par_en, rx_en, tx_en}
//  baud_div    out  DIV_WIDTH   baud divisor
//  irq         out  1           interrupt request, level
// BEHAVIOUR
//  Register map:
//   0x00 TXDATA  WO
//   0x04 RXDATA  RO
//   0x08 CTRL    RW [4:0]
//   0x0C BAUD    RW
//   0x10 STATUS  RO {rx_full, rx_empty, tx_full, tx_empty, tx_busy}
//   0x14 IER     RW [3:0]
//   0x18 ISR     R/W1C [3:0]
//   Unmapped: reads return 0, writes are ignored.
//  Reads:
//   - prdata is combinational from paddr while rd_en=1; prdata=0 whenever rd_en=0.
//   - Read latency 0, since pready is tied high.
//  Writes: registers update on the pclk edge where wr_en=1; each access is a single cycle.
//  TXDATA write:
//   - If ~tx_full: tx_push=1 for that cycle, tx_wdata=pwdata[7:0].
//   - If tx_full: no push, the byte is dropped, ISR[3] TX_OVF is set.
//  RXDATA read:
//   - If ~rx_empty: prdata=rx_rdata and rx_pop=1 in the same cycle.
//   - If rx_empty: prdata=0 and no pop.
//  tx_push and rx_pop are combinational from wr_en/rd_en, so each is exactly one pulse per APB access.
//  ISR set sources:
//   - [0] RX_AVAIL on rx_push
//   - [1] TX_EMPTY on the rising edge of tx_empty; needs a registered tx_empty_q
//   - [2] RX_OVR on rx_ovr
//   - [3] TX_OVF as above
//  ISR clear: a write of 1 clears the bit; a set event in the same cycle wins over the clear.
//  irq = |(ISR & IER); registered, so it asserts 1 cycle after the set edge.
//  Reset values:
//   - CTRL=0, BAUD=BAUD_RST, IER=0, ISR=0, tx_empty_q=1.
//   - irq=0, prdata=0, tx_push=0, rx_pop=0, pslverr=0.
//  Reset mid-access: all state clears asynchronously; a strobe sampled in reset has no effect.
//  rd_en and wr_en are mutually exclusive by construction. If both are seen, wr_en takes priority and the read returns 0.
// CONFIGURATION
//  UART_PSLVERR_EN defined:
//   - pslverr=1, combinationally with the strobe, on: an unmapped address, a write to RXDATA/STATUS, or a read of TXDATA.
//   - Register side effects are suppressed in the erroring cycle.
//  UART_PSLVERR_EN undefined: pslverr is tied 0 and the port is kept for a stable interface.
// STRUCTURE
//  Package uart_reg_pkg: register offsets, CTRL bit indices, ISR bit indices, STATUS field order.
//  Sub-module uart_irq_ctrl: ISR sticky bits, W1C and set priority, tx_empty edge detect, registered irq.
//  State elements use the common dff flop with reset_b=preset_n.
// TESTING
//  1. Reset -> BAUD reads 54, CTRL/IER/ISR read 0, irq=0, tx_push=rx_pop=0.
//  2. Write 0x00=0xA5 with tx_full=0 -> one tx_push pulse with tx_wdata=0xA5.
//     Repeat with tx_full=1 -> no push, ISR reads 0x8; with IER=0x8, irq=1 one cycle later.
//  3. rx_rdata=0x3C, rx_empty=0, read 0x04 -> prdata=0x3C and one rx_pop.
//     With rx_empty=1 -> prdata=0, no pop.
//  4. Pulse rx_push, then write ISR=0x1 in the same cycle as a second rx_push -> ISR[0] stays 1.
//     Write 0x1 again with no event -> ISR reads 0.
//  5. Write CTRL=0x1F and BAUD=0x1234 -> ctrl_o=0x1F, baud_div=0x1234, readback matches.
//     Write to 0x1C -> no state change, read returns 0.
//  6. With UART_PSLVERR_EN: write 0x10 -> pslverr=1 for that cycle, STATUS unaffected.
//     Without the macro -> pslverr=0.

Source files
------------

// File: rtl/uart_apb_regfile_pkg.sv
// ----------------------------------------------------------------------------
// uart_reg_pkg
// Register offsets, field bit positions and address decode helper shared by
// the UART register bank and its interrupt controller.
// ----------------------------------------------------------------------------
package uart_reg_pkg;

  // Register byte offsets (word aligned)
  localparam logic [31:0] OFF_TXDATA = 32'h00;
  localparam logic [31:0] OFF_RXDATA = 32'h04;
  localparam logic [31:0] OFF_CTRL   = 32'h08;
  localparam logic [31:0] OFF_BAUD   = 32'h0C;
  localparam logic [31:0] OFF_STATUS = 32'h10;
  localparam logic [31:0] OFF_IER    = 32'h14;
  localparam logic [31:0] OFF_ISR    = 32'h18;

  // CTRL fields: {stop2, par_odd, par_en, rx_en, tx_en}
  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_RX_EN   = 1;
  localparam int CTRL_PAR_EN  = 2;
  localparam int CTRL_PAR_ODD = 3;
  localparam int CTRL_STOP2   = 4;
  localparam int CTRL_W       = 5;

  // ISR / IER fields
  localparam int ISR_RX_AVAIL = 0;
  localparam int ISR_TX_EMPTY = 1;
  localparam int ISR_RX_OVR   = 2;
  localparam int ISR_TX_OVF   = 3;
  localparam int ISR_W        = 4;

  // STATUS fields: {rx_full, rx_empty, tx_full, tx_empty, tx_busy}
  localparam int STAT_TX_BUSY  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_TX_FULL  = 2;
  localparam int STAT_RX_EMPTY = 3;
  localparam int STAT_RX_FULL  = 4;
  localparam int STAT_W        = 5;

  typedef enum logic [2:0] {
    SEL_TXDATA,
    SEL_RXDATA,
    SEL_CTRL,
    SEL_BAUD,
    SEL_STATUS,
    SEL_IER,
    SEL_ISR,
    SEL_NONE
  } reg_sel_e;

  // Byte address -> register select; the two LSBs never take part.
  function automatic reg_sel_e reg_decode(input logic [31:0] byte_addr);
    logic [31:0] word_addr;
    word_addr = byte_addr & ~32'h3;
    case (word_addr)
      OFF_TXDATA: reg_decode = SEL_TXDATA;
      OFF_RXDATA: reg_decode = SEL_RXDATA;
      OFF_CTRL:   reg_decode = SEL_CTRL;
      OFF_BAUD:   reg_decode = SEL_BAUD;
      OFF_STATUS: reg_decode = SEL_STATUS;
      OFF_IER:    reg_decode = SEL_IER;
      OFF_ISR:    reg_decode = SEL_ISR;
      default:    reg_decode = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_apb_regfile_if.sv
// ----------------------------------------------------------------------------
// uart_apb_regfile_if
// Register-access port between the APB access FSM (master) and the UART
// register bank (slave).
//   paddr/pwdata   address and write data
//   rd_en/wr_en    single-cycle access strobes
//   prdata/pslverr read data and error, combinational with the strobe
// ----------------------------------------------------------------------------
interface uart_apb_regfile_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output paddr, pwdata, rd_en, wr_en,
    input  prdata, pslverr
  );

  modport slave (
    input  paddr, pwdata, rd_en, wr_en,
    output prdata, pslverr
  );
endinterface

// File: rtl/uart_apb_regfile_irq_ctrl.sv
// ----------------------------------------------------------------------------
// uart_irq_ctrl
// Sticky interrupt status bits with write-1-to-clear, set-over-clear priority,
// tx_empty rising-edge detection and a registered level interrupt.
// Ports:
//   pclk, preset_n  clock, async active-low reset
//   rx_push, rx_ovr receiver events
//   tx_empty        TX FIFO empty level (edge detected here)
//   tx_ovf_set      TXDATA write dropped because the FIFO was full
//   isr_clr         W1C mask, already qualified by a valid ISR write
//   ier             interrupt enables
//   isr             current status bits
//   irq             |(isr & ier), one cycle behind isr
// ----------------------------------------------------------------------------
module uart_irq_ctrl
  import uart_reg_pkg::*;
(
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             rx_push,
  input  logic             rx_ovr,
  input  logic             tx_empty,
  input  logic             tx_ovf_set,
  input  logic [ISR_W-1:0] isr_clr,
  input  logic [ISR_W-1:0] ier,
  output logic [ISR_W-1:0] isr,
  output logic             irq
);

  logic [ISR_W-1:0] isr_q, isr_d, isr_set;
  logic             tx_empty_q, tx_empty_d;
  logic             irq_q, irq_d;

  always_comb begin
    isr_set               = '0;
    isr_set[ISR_RX_AVAIL] = rx_push;
    isr_set[ISR_TX_EMPTY] = tx_empty & ~tx_empty_q;
    isr_set[ISR_RX_OVR]   = rx_ovr;
    isr_set[ISR_TX_OVF]   = tx_ovf_set;
    // set is OR-ed after the clear so a same-cycle event survives
    isr_d      = (isr_q & ~isr_clr) | isr_set;
    tx_empty_d = tx_empty;
    irq_d      = |(isr_q & ier);
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      isr_q      <= '0;
      tx_empty_q <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      isr_q      <= isr_d;
      tx_empty_q <= tx_empty_d;
      irq_q      <= irq_d;
    end
  end

  assign isr = isr_q;
  assign irq = irq_q;

endmodule

// File: rtl/uart_apb_regfile.sv
// ----------------------------------------------------------------------------
// uart_apb_regfile
// UART register bank behind the APB access FSM. Decodes rd_en/wr_en strobes,
// holds CTRL/BAUD/IER, bridges TXDATA writes to TX FIFO pushes and RXDATA
// reads to RX FIFO pops, and hosts the interrupt controller.
// Ports:
//   pclk, preset_n            clock, async active-low reset
//   bus (slave)               paddr/pwdata/rd_en/wr_en in, prdata/pslverr out
//   tx_wdata, tx_push         TX FIFO write side
//   tx_full/tx_empty/tx_busy  TX status
//   rx_rdata, rx_pop          RX FIFO show-ahead head and pop
//   rx_empty/rx_full          RX status
//   rx_push, rx_ovr           receiver events
//   ctrl_o, baud_div          configuration outputs
//   irq                       level interrupt
// Build option: UART_PSLVERR_EN enables pslverr on unmapped addresses,
// writes to RXDATA/STATUS and reads of TXDATA; otherwise pslverr is 0.
// ----------------------------------------------------------------------------
module uart_apb_regfile
  import uart_reg_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 5,
  parameter int                   DATA_WIDTH = 32,
  parameter int                   DIV_WIDTH  = 16,
  parameter logic [DIV_WIDTH-1:0] BAUD_RST   = DIV_WIDTH'(54)
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  uart_apb_regfile_if.slave    bus,
  output logic [7:0]           tx_wdata,
  output logic                 tx_push,
  input  logic                 tx_full,
  input  logic                 tx_empty,
  input  logic                 tx_busy,
  input  logic [7:0]           rx_rdata,
  output logic                 rx_pop,
  input  logic                 rx_empty,
  input  logic                 rx_full,
  input  logic                 rx_push,
  input  logic                 rx_ovr,
  output logic [CTRL_W-1:0]    ctrl_o,
  output logic [DIV_WIDTH-1:0] baud_div,
  output logic                 irq
);

  reg_sel_e    sel;
  logic        wr, rd;
  logic        acc_err;
  logic        wr_ok, rd_ok;
  logic [31:0] addr_ext;

  assign addr_ext = 32'(bus.paddr);
  assign sel      = reg_decode(addr_ext);
  // wr_en wins if both strobes ever appear together
  assign wr       = bus.wr_en;
  assign rd       = bus.rd_en & ~bus.wr_en;

`ifdef UART_PSLVERR_EN
  assign acc_err = (wr | rd) &
                   ((sel == SEL_NONE) |
                    (wr & ((sel == SEL_RXDATA) | (sel == SEL_STATUS))) |
                    (rd & (sel == SEL_TXDATA)));
`else
  assign acc_err = 1'b0;
`endif

  assign wr_ok       = wr & ~acc_err;
  assign rd_ok       = rd & ~acc_err;
  assign bus.pslverr = acc_err;

  // Configuration registers
  logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
  logic [DIV_WIDTH-1:0] baud_q, baud_d;
  logic [ISR_W-1:0]     ier_q, ier_d;

  always_comb begin
    ctrl_d = ctrl_q;
    baud_d = baud_q;
    ier_d  = ier_q;
    if (wr_ok) begin
      case (sel)
        SEL_CTRL: ctrl_d = bus.pwdata[CTRL_W-1:0];
        SEL_BAUD: baud_d = bus.pwdata[DIV_WIDTH-1:0];
        SEL_IER:  ier_d  = bus.pwdata[ISR_W-1:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ctrl_q <= '0;
      baud_q <= BAUD_RST;
      ier_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      baud_q <= baud_d;
      ier_q  <= ier_d;
    end
  end

  assign ctrl_o   = ctrl_q;
  assign baud_div = baud_q;

  // TX bridge: a push when there is room, otherwise flag the dropped byte
  logic tx_wr, tx_ovf_set;
  assign tx_wr      = wr_ok & (sel == SEL_TXDATA);
  assign tx_push    = tx_wr & ~tx_full;
  assign tx_ovf_set = tx_wr & tx_full;
  assign tx_wdata   = bus.pwdata[7:0];

  // Interrupts
  logic [ISR_W-1:0] isr, isr_clr;
  assign isr_clr = (wr_ok && sel == SEL_ISR) ? bus.pwdata[ISR_W-1:0] : '0;

  uart_irq_ctrl u_irq_ctrl (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .rx_push    (rx_push),
    .rx_ovr     (rx_ovr),
    .tx_empty   (tx_empty),
    .tx_ovf_set (tx_ovf_set),
    .isr_clr    (isr_clr),
    .ier        (ier_q),
    .isr        (isr),
    .irq        (irq)
  );

  // Status word
  logic [STAT_W-1:0] status;
  always_comb begin
    status                = '0;
    status[STAT_TX_BUSY]  = tx_busy;
    status[STAT_TX_EMPTY] = tx_empty;
    status[STAT_TX_FULL]  = tx_full;
    status[STAT_RX_EMPTY] = rx_empty;
    status[STAT_RX_FULL]  = rx_full;
  end

  // Read mux; zero whenever no valid read is in progress
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rx_pop_c;

  always_comb begin
    rd_data  = '0;
    rx_pop_c = 1'b0;
    if (rd_ok) begin
      case (sel)
        SEL_RXDATA: begin
          if (!rx_empty) begin
            rd_data[7:0] = rx_rdata;
            rx_pop_c     = 1'b1;
          end
        end
        SEL_CTRL:   rd_data[CTRL_W-1:0]    = ctrl_q;
        SEL_BAUD:   rd_data[DIV_WIDTH-1:0] = baud_q;
        SEL_STATUS: rd_data[STAT_W-1:0]    = status;
        SEL_IER:    rd_data[ISR_W-1:0]     = ier_q;
        SEL_ISR:    rd_data[ISR_W-1:0]     = isr;
        default:    ;
      endcase
    end
  end

  assign bus.prdata = rd_data;
  assign rx_pop     = rx_pop_c;

  // Write data above the widest register is never stored
  logic unused_pwdata;
  assign unused_pwdata = ^bus.pwdata[DATA_WIDTH-1:DIV_WIDTH];

endmodule

// File: tb/tb_uart_apb_regfile.sv
module tb_uart_apb_regfile;

  logic pclk = 1'b0;
  logic preset_n;
  always #5 pclk = ~pclk;

  uart_apb_regfile_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  logic [7:0]  tx_wdata;
  logic        tx_push, tx_full, tx_empty, tx_busy;
  logic [7:0]  rx_rdata;
  logic        rx_pop, rx_empty, rx_full, rx_push, rx_ovr;
  logic [4:0]  ctrl_o;
  logic [15:0] baud_div;
  logic        irq;

  uart_apb_regfile dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus),
    .tx_wdata (tx_wdata),
    .tx_push  (tx_push),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .tx_busy  (tx_busy),
    .rx_rdata (rx_rdata),
    .rx_pop   (rx_pop),
    .rx_empty (rx_empty),
    .rx_full  (rx_full),
    .rx_push  (rx_push),
    .rx_ovr   (rx_ovr),
    .ctrl_o   (ctrl_o),
    .baud_div (baud_div),
    .irq      (irq)
  );

`ifdef UART_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [4:0]  m_ctrl;
  logic [15:0] m_baud;
  logic [3:0]  m_ier, m_isr;
  logic        m_irq, m_txe_prev;

  // Values sampled in the most recent cycle
  logic [31:0] s_prdata;
  logic [7:0]  s_wdata;
  logic        s_push, s_pop, s_err, s_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ctrl     = 5'h0;
    m_baud     = 16'd54;
    m_ier      = 4'h0;
    m_isr      = 4'h0;
    m_irq      = 1'b0;
    m_txe_prev = 1'b1;
  endtask

  function automatic int word_addr();
    return int'(bus.paddr) / 4;
  endfunction

  function automatic bit m_wr();
    return bus.wr_en === 1'b1;
  endfunction

  function automatic bit m_rd();
    return bus.rd_en === 1'b1 && bus.wr_en !== 1'b1;
  endfunction

  function automatic bit m_err();
    int a;
    a = word_addr();
    if (!ERR_EN) return 1'b0;
    if (m_wr()) return (a > 6) || (a == 1) || (a == 4);
    if (m_rd()) return (a > 6) || (a == 0);
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_prdata();
    if (!m_rd() || m_err()) return 32'h0;
    case (word_addr())
      1: return rx_empty ? 32'h0 : 32'(rx_rdata);
      2: return 32'(m_ctrl);
      3: return 32'(m_baud);
      4: return 32'({rx_full, rx_empty, tx_full, tx_empty, tx_busy});
      5: return 32'(m_ier);
      6: return 32'(m_isr);
      default: return 32'h0;
    endcase
  endfunction

  // One clock: check combinational outputs mid-cycle, then advance the model
  task automatic tick();
    bit          wr, rd, err;
    int          a;
    logic        exp_push, exp_pop;
    logic [31:0] exp_rd;
    logic [3:0]  set, clr;
    @(negedge pclk);
    wr       = m_wr();
    rd       = m_rd();
    a        = word_addr();
    err      = m_err();
    exp_push = wr && a == 0 && !tx_full && !err;
    exp_pop  = rd && a == 1 && !rx_empty && !err;
    exp_rd   = m_prdata();
    s_prdata = bus.prdata;
    s_wdata  = tx_wdata;
    s_push   = tx_push;
    s_pop    = rx_pop;
    s_err    = bus.pslverr;
    s_irq    = irq;
    chk("prdata",   s_prdata,        exp_rd);
    chk("tx_push",  32'(s_push),     32'(exp_push));
    chk("rx_pop",   32'(s_pop),      32'(exp_pop));
    chk("pslverr",  32'(s_err),      32'(err));
    chk("irq",      32'(s_irq),      32'(m_irq));
    chk("ctrl_o",   32'(ctrl_o),     32'(m_ctrl));
    chk("baud_div", 32'(baud_div),   32'(m_baud));
    if (exp_push) chk("tx_wdata", 32'(s_wdata), 32'(bus.pwdata[7:0]));
    @(posedge pclk);
    if (!preset_n) begin
      m_reset();
    end else begin
      set = {wr && a == 0 && tx_full && !err, rx_ovr, tx_empty && !m_txe_prev, rx_push};
      clr = (wr && a == 6 && !err) ? bus.pwdata[3:0] : 4'h0;
      m_irq = |(m_isr & m_ier);
      m_isr = (m_isr & ~clr) | set;
      m_txe_prev = tx_empty;
      if (wr && !err) begin
        case (a)
          2: m_ctrl = bus.pwdata[4:0];
          3: m_baud = bus.pwdata[15:0];
          5: m_ier  = bus.pwdata[3:0];
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    bus.paddr  = addr;
    bus.pwdata = data;
    bus.wr_en  = 1'b1;
    tick();
    bus.wr_en  = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr);
    bus.paddr = addr;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.paddr  = '0;
    bus.pwdata = '0;
    bus.rd_en  = 1'b0;
    bus.wr_en  = 1'b0;
    tx_full    = 1'b0;
    tx_empty   = 1'b1;
    tx_busy    = 1'b0;
    rx_rdata   = 8'h0;
    rx_empty   = 1'b1;
    rx_full    = 1'b0;
    rx_push    = 1'b0;
    rx_ovr     = 1'b0;
    preset_n   = 1'b0;
    m_reset();
    idle(2);
    preset_n = 1'b1;

    // Reset values
    rd(5'h0C); chk("rst_baud", s_prdata, 32'd54);
    chk("rst_push", 32'(s_push), 32'h0);
    rd(5'h08); chk("rst_ctrl", s_prdata, 32'h0);
    rd(5'h14); chk("rst_ier",  s_prdata, 32'h0);
    rd(5'h18); chk("rst_isr",  s_prdata, 32'h0);
    chk("rst_irq", 32'(s_irq), 32'h0);

    // TXDATA push and overflow
    wr(5'h00, 32'h0000_00A5);
    chk("tx_push_a5",  32'(s_push),  32'h1);
    chk("tx_wdata_a5", 32'(s_wdata), 32'hA5);
    idle(1);
    chk("tx_push_single", 32'(s_push), 32'h0);
    wr(5'h14, 32'h8);
    tx_full = 1'b1;
    wr(5'h00, 32'h5A);
    chk("ovf_nopush", 32'(s_push), 32'h0);
    tx_full = 1'b0;
    rd(5'h18);
    chk("isr_ovf", s_prdata, 32'h8);
    chk("irq_latency", 32'(s_irq), 32'h0);
    idle(1);
    chk("irq_ovf", 32'(s_irq), 32'h1);
    wr(5'h18, 32'hF);
    idle(2);
    chk("irq_cleared", 32'(s_irq), 32'h0);
    wr(5'h14, 32'h0);

    // RXDATA pop
    rx_rdata = 8'h3C;
    rx_empty = 1'b0;
    rd(5'h04);
    chk("rx_data", s_prdata, 32'h3C);
    chk("rx_pop",  32'(s_pop), 32'h1);
    rx_empty = 1'b1;
    rd(5'h04);
    chk("rx_empty_data", s_prdata, 32'h0);
    chk("rx_empty_pop",  32'(s_pop), 32'h0);

    // W1C vs set priority
    rx_push = 1'b1; idle(1); rx_push = 1'b0;
    rd(5'h18); chk("isr_rx_set", s_prdata, 32'h1);
    rx_push = 1'b1;
    wr(5'h18, 32'h1);
    rx_push = 1'b0;
    rd(5'h18); chk("isr_set_wins", s_prdata, 32'h1);
    wr(5'h18, 32'h1);
    rd(5'h18); chk("isr_w1c", s_prdata, 32'h0);

    // CTRL/BAUD and an unmapped write
    wr(5'h08, 32'h1F);
    wr(5'h0C, 32'h1234);
    chk("ctrl_o_1f",  32'(ctrl_o),   32'h1F);
    chk("baud_1234",  32'(baud_div), 32'h1234);
    rd(5'h08); chk("ctrl_rb", s_prdata, 32'h1F);
    rd(5'h0D); chk("baud_rb_lsb_ignored", s_prdata, 32'h1234);
    wr(5'h1C, 32'hFFFF_FFFF);
    rd(5'h08); chk("ctrl_after_unmapped", s_prdata, 32'h1F);
    rd(5'h0C); chk("baud_after_unmapped", s_prdata, 32'h1234);
    rd(5'h1C); chk("unmapped_rd", s_prdata, 32'h0);

    // Write to STATUS
    tx_busy = 1'b1;
    wr(5'h10, 32'h0);
    chk("pslverr_status", 32'(s_err), 32'(ERR_EN));
    rd(5'h10); chk("status_rb", s_prdata, 32'h0B);
    tx_busy = 1'b0;

    // Both strobes: write wins, read returns 0
    bus.paddr = 5'h08; bus.pwdata = 32'h3;
    bus.rd_en = 1'b1;  bus.wr_en  = 1'b1;
    tick();
    bus.rd_en = 1'b0;  bus.wr_en  = 1'b0;
    chk("both_rd0",   s_prdata,       32'h0);
    chk("both_write", 32'(ctrl_o),    32'h3);

    // Reset in the middle of a write
    bus.paddr = 5'h08; bus.pwdata = 32'h15; bus.wr_en = 1'b1;
    preset_n = 1'b0;
    m_reset();
    tick();
    bus.wr_en = 1'b0;
    preset_n = 1'b1;
    rd(5'h08); chk("midrst_ctrl", s_prdata, 32'h0);
    rd(5'h0C); chk("midrst_baud", s_prdata, 32'd54);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int op;
      op         = int'($urandom_range(0, 3));
      bus.paddr  = 5'($urandom_range(0, 31));
      bus.pwdata = $urandom;
      bus.rd_en  = (op == 1);
      bus.wr_en  = (op == 2);
      tx_full    = ($urandom_range(0, 3) == 0);
      tx_empty   = ($urandom_range(0, 1) == 0);
      tx_busy    = $urandom_range(0, 1) == 1;
      rx_rdata   = 8'($urandom);
      rx_empty   = ($urandom_range(0, 2) == 0);
      rx_full    = ($urandom_range(0, 3) == 0);
      rx_push    = ($urandom_range(0, 5) == 0);
      rx_ovr     = ($urandom_range(0, 9) == 0);
      tick();
    end
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    rx_push   = 1'b0;
    rx_ovr    = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
